// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: shared opcode/funct constants, ALU control encodings and
// the combinational control decoder used by the MIPS decode stage.
// Optional feature macro: DECODE_BNE_EN (adds bne, op 000101).
package decode_stage_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_BUBBLE = 6'b111111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_dst;
        logic       branch;     // beq
        logic       branch_ne;  // bne (only when DECODE_BNE_EN)
        logic       jump;
        logic [2:0] alu_ctrl;
    } ctrl_t;

    // Unknown opcodes/functs (including the bubble) fall through to all-zero.
    function automatic ctrl_t decode_ctrl(input logic [5:0] op, input logic [5:0] funct);
        ctrl_t c;
        c = '0;
        case (op)
            OP_RTYPE: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
                case (funct)
                    FN_ADD:  c.alu_ctrl = ALU_ADD;
                    FN_SUB:  c.alu_ctrl = ALU_SUB;
                    FN_AND:  c.alu_ctrl = ALU_AND;
                    FN_OR:   c.alu_ctrl = ALU_OR;
                    FN_SLT:  c.alu_ctrl = ALU_SLT;
                    default: c = '0;
                endcase
            end
            OP_LW: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.alu_src    = 1'b1;
                c.alu_ctrl   = ALU_ADD;
            end
            OP_SW: begin
                c.mem_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_ctrl  = ALU_ADD;
            end
            OP_ADDI: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_ctrl  = ALU_ADD;
            end
            OP_BEQ: c.branch = 1'b1;
`ifdef DECODE_BNE_EN
            OP_BNE: c.branch_ne = 1'b1;
`endif
            OP_J:   c.jump = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// reg_file: 32x32 register file for the decode stage.
//   clk, rst_n      clock, async active-low reset (clears array if REG_INIT_ZERO)
//   we, wa, wd      writeback port (writes to r0 are dropped)
//   ra1/ra2 -> rd1/rd2  combinational reads with same-cycle writeback bypass
module reg_file #(
    parameter bit REG_INIT_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    import decode_stage_pkg::*;

    logic [31:0] regs [32];
    logic        wr_en;

    assign wr_en = we && (wa != 5'd0);

    generate
        if (REG_INIT_ZERO) begin : g_rst
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < 32; i++) regs[i] <= '0;
                end else if (wr_en) begin
                    regs[wa] <= wd;
                end
            end
        end else begin : g_norst
            always_ff @(posedge clk) begin
                if (wr_en) regs[wa] <= wd;
            end
        end
    endgenerate

    // r0 is hard zero; a write landing this cycle is visible immediately.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (ra1 != 5'd0) rd1 = (wr_en && wa == ra1) ? wd : regs[ra1];
        if (ra2 != 5'd0) rd2 = (wr_en && wa == ra2) ? wd : regs[ra2];
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: MIPS ID stage. Decodes InstrD, reads the register file,
// resolves branches/jumps early (PCSrcD/PCBranchD back to fetch) and
// registers control + operands into the ID/EX register (the *E outputs).
//   Inputs : InstrD, PCPlus1D, StallD, FlushE, ForwardAD/BD, ALUOutM,
//            RegWriteW, WriteRegW, ResultW
//   Outputs: PCSrcD, PCBranchD, RsD, RtD, BranchD, and ID/EX fields
// Optional feature macro: DECODE_BNE_EN (adds bne with condition ~EqualD).
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int PC_SIZE       = 8,
    parameter bit REG_INIT_ZERO = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        InstrD,
    input  logic [PC_SIZE-1:0] PCPlus1D,
    input  logic               StallD,
    input  logic               FlushE,
    input  logic               ForwardAD,
    input  logic               ForwardBD,
    input  logic [31:0]        ALUOutM,
    input  logic               RegWriteW,
    input  logic [4:0]         WriteRegW,
    input  logic [31:0]        ResultW,
    output logic               PCSrcD,
    output logic [PC_SIZE-1:0] PCBranchD,
    output logic [4:0]         RsD,
    output logic [4:0]         RtD,
    output logic               BranchD,
    output logic               RegWriteE,
    output logic               MemtoRegE,
    output logic               MemWriteE,
    output logic               ALUSrcE,
    output logic               RegDstE,
    output logic [2:0]         ALUControlE,
    output logic [31:0]        RD1E,
    output logic [31:0]        RD2E,
    output logic [31:0]        SignImmE,
    output logic [4:0]         RsE,
    output logic [4:0]         RtE,
    output logic [4:0]         RdE
);

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_write;
        logic        alu_src;
        logic        reg_dst;
        logic [2:0]  alu_ctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] simm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } idex_t;

    ctrl_t       ctrl;
    logic [31:0] sign_imm, rd1, rd2, cmp_a, cmp_b;
    logic        equal_d, take;
    idex_t       idex_d, idex_q;

    assign ctrl     = decode_ctrl(InstrD[31:26], InstrD[5:0]);
    assign sign_imm = {{16{InstrD[15]}}, InstrD[15:0]};
    assign RsD      = InstrD[25:21];
    assign RtD      = InstrD[20:16];

    reg_file #(.REG_INIT_ZERO(REG_INIT_ZERO)) u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (RegWriteW),
        .wa    (WriteRegW),
        .wd    (ResultW),
        .ra1   (InstrD[25:21]),
        .ra2   (InstrD[20:16]),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    // Early branch resolution; the memory-stage result can be forwarded in.
    assign cmp_a   = ForwardAD ? ALUOutM : rd1;
    assign cmp_b   = ForwardBD ? ALUOutM : rd2;
    assign equal_d = (cmp_a == cmp_b);
    assign take    = (ctrl.branch & equal_d) | (ctrl.branch_ne & ~equal_d) | ctrl.jump;

    // Operands may be stale while stalled, so never redirect then.
    assign PCSrcD    = take & ~StallD;
    assign BranchD   = ctrl.branch | ctrl.branch_ne | ctrl.jump;
    assign PCBranchD = ctrl.jump ? InstrD[PC_SIZE-1:0]
                                 : PCPlus1D + sign_imm[PC_SIZE-1:0];

    assign idex_d = '{
        reg_write:  ctrl.reg_write,
        mem_to_reg: ctrl.mem_to_reg,
        mem_write:  ctrl.mem_write,
        alu_src:    ctrl.alu_src,
        reg_dst:    ctrl.reg_dst,
        alu_ctrl:   ctrl.alu_ctrl,
        rd1:        rd1,
        rd2:        rd2,
        simm:       sign_imm,
        rs:         InstrD[25:21],
        rt:         InstrD[20:16],
        rd:         InstrD[15:11]
    };

    // StallD deliberately not used here: the hazard unit pairs it with FlushE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      idex_q <= '0;
        else if (FlushE) idex_q <= '0;
        else             idex_q <= idex_d;
    end

    assign RegWriteE   = idex_q.reg_write;
    assign MemtoRegE   = idex_q.mem_to_reg;
    assign MemWriteE   = idex_q.mem_write;
    assign ALUSrcE     = idex_q.alu_src;
    assign RegDstE     = idex_q.reg_dst;
    assign ALUControlE = idex_q.alu_ctrl;
    assign RD1E        = idex_q.rd1;
    assign RD2E        = idex_q.rd2;
    assign SignImmE    = idex_q.simm;
    assign RsE         = idex_q.rs;
    assign RtE         = idex_q.rt;
    assign RdE         = idex_q.rd;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: table-driven bench for decode_stage. Combinational branch
// outputs are checked as each vector is applied; expected ID/EX contents are
// queued and compared one clock later. Hand-written sequences cover reset.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] InstrD;
    logic [7:0]  PCPlus1D;
    logic        StallD, FlushE, ForwardAD, ForwardBD;
    logic [31:0] ALUOutM;
    logic        RegWriteW;
    logic [4:0]  WriteRegW;
    logic [31:0] ResultW;
    logic        PCSrcD;
    logic [7:0]  PCBranchD;
    logic [4:0]  RsD, RtD;
    logic        BranchD;
    logic        RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, SignImmE;
    logic [4:0]  RsE, RtE, RdE;

    always #5 clk = ~clk;

    decode_stage #(.PC_SIZE(8), .REG_INIT_ZERO(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .InstrD(InstrD), .PCPlus1D(PCPlus1D),
        .StallD(StallD), .FlushE(FlushE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .ALUOutM(ALUOutM), .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
        .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .RsD(RsD), .RtD(RtD), .BranchD(BranchD),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE), .RsE(RsE), .RtE(RtE), .RdE(RdE)
    );

    // control byte: {RegWrite, MemtoReg, MemWrite, ALUSrc, RegDst, ALUControl[2:0]}
    localparam logic [7:0] C_NONE = 8'h00, C_ADD = 8'h8A, C_SUB = 8'h8E, C_AND = 8'h88,
                           C_OR = 8'h89, C_SLT = 8'h8F, C_LW = 8'hD2, C_SW = 8'h32,
                           C_ADDI = 8'h92;
    localparam logic [31:0] BUBBLE = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [31:0] instr;
        logic [7:0]  pcp1;
        logic        stall, flush, fa, fb;
        logic [31:0] aluoutm;
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] res;
        logic        pcsrc, br;
        logic [7:0]  pcb;
        logic [7:0]  ctl;
        logic [31:0] rd1, rd2;
    } vec_t;

    vec_t         vt[$];
    logic [118:0] sb[$];
    int           n_cmp = 0;
    int           n_bad = 0;

    function automatic vec_t mk(input logic [31:0] instr, input logic [7:0] pcp1,
                                input logic stall, input logic flush, input logic fa,
                                input logic fb, input logic [31:0] aluoutm,
                                input logic rw, input logic [4:0] wr, input logic [31:0] res,
                                input logic pcsrc, input logic br, input logic [7:0] pcb,
                                input logic [7:0] ctl, input logic [31:0] rd1,
                                input logic [31:0] rd2);
        vec_t v;
        v = '{instr, pcp1, stall, flush, fa, fb, aluoutm, rw, wr, res, pcsrc, br, pcb, ctl, rd1, rd2};
        return v;
    endfunction

    // Preload a register while a bubble sits in decode (r31 is never written).
    function automatic vec_t wr_reg(input logic [4:0] r, input logic [31:0] val);
        return mk(BUBBLE, 8'h00, 0, 0, 0, 0, 0, 1, r, val, 0, 0, 8'h00, C_NONE, 0, 0);
    endfunction

    function automatic vec_t op(input logic [31:0] instr, input logic [7:0] ctl,
                                input logic [31:0] rd1, input logic [31:0] rd2);
        return mk(instr, 8'h00, 0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 8'h00, ctl, rd1, rd2);
    endfunction

    function automatic logic [118:0] e_actual();
        return {RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE,
                RD1E, RD2E, SignImmE, RsE, RtE, RdE};
    endfunction

    task automatic chk(input string name, input logic [118:0] act, input logic [118:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        logic [31:0] simm;
        @(negedge clk);
        InstrD = v.instr; PCPlus1D = v.pcp1; StallD = v.stall; FlushE = v.flush;
        ForwardAD = v.fa; ForwardBD = v.fb; ALUOutM = v.aluoutm;
        RegWriteW = v.rw; WriteRegW = v.wr; ResultW = v.res;
        #1;
        chk($sformatf("PCSrcD[%08h]", v.instr), {118'd0, PCSrcD}, {118'd0, v.pcsrc});
        chk($sformatf("BranchD[%08h]", v.instr), {118'd0, BranchD}, {118'd0, v.br});
        if (v.br) chk($sformatf("PCBranchD[%08h]", v.instr), {111'd0, PCBranchD}, {111'd0, v.pcb});
        simm = {{16{v.instr[15]}}, v.instr[15:0]};
        if (v.flush) sb.push_back('0);
        else sb.push_back({v.ctl, v.rd1, v.rd2, simm, v.instr[25:21], v.instr[20:16], v.instr[15:11]});
    endtask

    // Scoreboard: each queued expectation is due one clock after it was driven.
    always @(posedge clk) begin
        logic [118:0] e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("idex", e_actual(), e);
        end
    end

    initial begin
        rst_n = 1'b0; InstrD = BUBBLE; PCPlus1D = '0; StallD = 0; FlushE = 0;
        ForwardAD = 0; ForwardBD = 0; ALUOutM = '0; RegWriteW = 0; WriteRegW = '0; ResultW = '0;

        // Reset with a bubble in decode: ID/EX cleared, no redirect.
        repeat (2) @(negedge clk);
        #1;
        chk("reset_idex", e_actual(), '0);
        chk("reset_pcsrc", {118'd0, PCSrcD}, 119'd0);
        @(negedge clk);
        rst_n = 1'b1;

        vt.push_back(wr_reg(5'd1, 32'd7));
        vt.push_back(wr_reg(5'd2, 32'd7));
        // add r3,r5,r0 with r5 written this same cycle -> bypass
        vt.push_back(mk(32'h00A01820, 8'h00, 0, 0, 0, 0, 0, 1, 5'd5, 32'h1234, 0, 0, 8'h00, C_ADD, 32'h1234, 0));
        // beq r1,r2,-3 from PC+1=0x10: taken to 0x0D; then stalled -> no redirect
        vt.push_back(mk(32'h1022FFFD, 8'h10, 0, 0, 0, 0, 0, 0, 5'd0, 0, 1, 1, 8'h0D, C_NONE, 7, 7));
        vt.push_back(mk(32'h1022FFFD, 8'h10, 1, 0, 0, 0, 0, 0, 5'd0, 0, 0, 1, 8'h0D, C_NONE, 7, 7));
        vt.push_back(wr_reg(5'd2, 32'd9));
        // forwarded A operand
        vt.push_back(mk(32'h1022FFFD, 8'h10, 0, 0, 1, 0, 32'd9, 0, 5'd0, 0, 1, 1, 8'h0D, C_NONE, 7, 9));
        vt.push_back(mk(32'h1022FFFD, 8'h10, 0, 0, 1, 0, 32'd8, 0, 5'd0, 0, 0, 1, 8'h0D, C_NONE, 7, 9));
        // forwarded B operand: beq r2,r1 with ALUOutM=9
        vt.push_back(mk(32'h1041FFFD, 8'h20, 0, 0, 0, 1, 32'd9, 0, 5'd0, 0, 1, 1, 8'h1D, C_NONE, 9, 7));
        // lw r4,8(r1) flushed, then loaded
        vt.push_back(mk(32'h8C240008, 8'h00, 0, 1, 0, 0, 0, 0, 5'd0, 0, 0, 0, 8'h00, C_LW, 7, 0));
        vt.push_back(op(32'h8C240008, C_LW, 7, 0));
        // write to r0 ignored, both bypass and array
        vt.push_back(mk(32'h00001820, 8'h00, 0, 0, 0, 0, 0, 1, 5'd0, 32'd5, 0, 0, 8'h00, C_ADD, 0, 0));
        vt.push_back(op(32'h00001820, C_ADD, 0, 0));
        // j 0xFF and beq wrap 0xFE+3 -> 0x01 (not taken: 7 != 9)
        vt.push_back(mk(32'h080000FF, 8'h00, 0, 0, 0, 0, 0, 0, 5'd0, 0, 1, 1, 8'hFF, C_NONE, 0, 0));
        vt.push_back(mk(32'h10220003, 8'hFE, 0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 1, 8'h01, C_NONE, 7, 9));
`ifdef DECODE_BNE_EN
        vt.push_back(mk(32'h14220003, 8'hFE, 0, 0, 0, 0, 0, 0, 5'd0, 0, 1, 1, 8'h01, C_NONE, 7, 9));
`else
        vt.push_back(mk(32'h14220003, 8'hFE, 0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 8'h01, C_NONE, 7, 9));
`endif
        vt.push_back(op(32'hAC220004, C_SW, 7, 9));
        vt.push_back(op(32'h2026FFFF, C_ADDI, 7, 0));
        vt.push_back(op(32'h00221822, C_SUB, 7, 9));
        vt.push_back(op(32'h00221824, C_AND, 7, 9));
        vt.push_back(op(32'h00221825, C_OR, 7, 9));
        vt.push_back(op(32'h0022182A, C_SLT, 7, 9));
        vt.push_back(op(32'h00221800, C_NONE, 7, 9));  // unknown funct -> no-op
        vt.push_back(op(BUBBLE, C_NONE, 0, 0));

        foreach (vt[i]) apply(vt[i]);

        @(negedge clk);
        RegWriteW = 0; FlushE = 0; StallD = 0; ForwardAD = 0; ForwardBD = 0;
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) chk("sb_drain", {87'd0, sb.size()}, 119'd0);

        // Asynchronous reset mid-operation: clears ID/EX at once and the regfile.
        InstrD = 32'h8C240008;
        @(posedge clk);
        #2;
        chk("pre_reset_regwriteE", {118'd0, RegWriteE}, {118'd0, 1'b1});
        rst_n = 1'b0;
        #1;
        chk("async_reset_idex", e_actual(), '0);
        @(negedge clk);
        rst_n = 1'b1;
        InstrD = 32'h00221820;  // add r3,r1,r2 after reset: r1/r2 cleared
        @(posedge clk);
        #1;
        chk("post_reset_rd1", {87'd0, RD1E}, 119'd0);
        chk("post_reset_rd2", {87'd0, RD2E}, 119'd0);
        chk("post_reset_ctl", {116'd0, ALUControlE}, {116'd0, 3'b010});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Second stage of the 5-stage MIPS pipeline, directly downstream of instruction fetch.
- Consumes InstrD and PCPlus1D.
- Reads the register file and decodes control.
- Resolves branches and jumps early, returning PCSrcD and PCBranchD to fetch.
- Registers operands and control into the ID/EX pipeline register for the execute stage.

Parameters:
- PC_SIZE, 8, width of the word-addressed PC (matches fetch).
- REG_INIT_ZERO, 1, when 1 the reset clears all 32 registers; when 0 only the ID/EX register is cleared.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- InstrD  in  32  instruction from the fetch pipeline register
- PCPlus1D  in  PC_SIZE  PC+1 of InstrD
- StallD  in  1  hazard unit: hold decode
- FlushE  in  1  hazard unit: insert bubble into ID/EX
- ForwardAD, ForwardBD  in  1 each  select ALUOutM for branch comparison operands A/B
- ALUOutM  in  32  memory-stage ALU result for branch forwarding
- RegWriteW  in  1  writeback enable
- WriteRegW  in  5  writeback register
- ResultW  in  32  writeback data
- PCSrcD  out  1  redirect fetch
- PCBranchD  out  PC_SIZE  redirect target
- RsD, RtD  out  5 each  source fields to the hazard unit
- BranchD  out  1  current instruction is a branch/jump, for the hazard unit
- RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE  out  1 each  registered control
- ALUControlE  out  3  registered ALU op
- RD1E, RD2E, SignImmE  out  32 each  registered operands
- RsE, RtE, RdE  out  5 each  registered register fields

Behaviour:
- Decode (combinational):
  - R-type (op 000000): funct add 100000→010, sub 100010→110, and 100100→000, or 100101→001, slt 101010→111. RegWrite=1, RegDst=1.
  - lw 100011: RegWrite, MemtoReg, ALUSrc, ALU 010.
  - sw 101011: MemWrite, ALUSrc, ALU 010.
  - addi 001000: RegWrite, ALUSrc, ALU 010.
  - beq 000100: Branch.
  - j 000010: Jump.
  - Any other op, including bubble 111111, and unknown funct: all control 0 (no-op).
- SignImm = sign-extended InstrD[15:0].
- Register file:
  - 32x32; r0 always reads 0 and ignores writes.
  - Synchronous write on the rising edge when RegWriteW and WriteRegW≠0.
  - Read is combinational with internal bypass: if RegWriteW and WriteRegW equals the read address (≠0), the read returns ResultW in the same cycle.
- Branch compare:
  - A = ForwardAD ? ALUOutM : RD1; B likewise with ForwardBD.
  - EqualD = (A==B).
- Branch and jump outputs:
  - PCSrcD = ((Branch & EqualD) | Jump) & ~StallD. It is never asserted while stalled, because operands may be stale.
  - PCBranchD = Jump ? InstrD[PC_SIZE-1:0] : PCPlus1D + SignImm[PC_SIZE-1:0], modulo 2^PC_SIZE, with wrap-around allowed.
- ID/EX register, rising edge, priority order:
  1. rst_n low: all E outputs go to 0 immediately (asynchronous).
  2. FlushE: all control and register fields go to 0; data fields go to 0.
  3. Otherwise: load the decoded values.
- The ID/EX register is not stalled by StallD. The hazard unit asserts FlushE with StallD.
- Latency: decode-to-E outputs is one cycle. Writeback-to-read is zero cycles, via the bypass.
- Reset mid-operation:
  - The asynchronous clear overrides any in-flight load.
  - The regfile clears only if REG_INIT_ZERO=1.
  - PCSrcD is combinational and follows InstrD. Fetch guarantees the bubble opcode, so PCSrcD reads 0 after fetch resets.

Optional Feature:
- DECODE_BNE_EN defined: adds bne (op 000101) with the branch condition ~EqualD. BranchD is also asserted for bne.
- DECODE_BNE_EN undefined: op 000101 decodes as a no-op.

Decomposition:
- Shared package/header:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J, OP_BUBBLE=6'b111111)
  - funct constants
  - ALUControl encodings (ALU_ADD=010, ALU_SUB=110, ALU_AND=000, ALU_OR=001, ALU_SLT=111)
- Sub-module: reg_file, containing the 32x32 array with the r0 rule, bypass and reset option.
- Control decode and the ID/EX register stay in decode_stage.

Test Plan:
- Reset then bubble: rst_n low, then InstrD=FFFF_FFFF → all E outputs 0, PCSrcD=0.
- Bypass: RegWriteW=1, WriteRegW=5, ResultW=0x1234, InstrD=add r3,r5,r0 → next cycle RD1E=0x1234, ALUControlE=010, RegDstE=1, RdE=3.
- beq taken: r1=r2=7, PCPlus1D=0x10, imm=-3 → PCSrcD=1, PCBranchD=0x0D. The same instruction with StallD=1 → PCSrcD=0.
- Forwarded branch: ForwardAD=1, ALUOutM=9, r2=9, beq → PCSrcD=1. With ALUOutM=8 → PCSrcD=0.
- Flush priority: FlushE=1 with lw in decode → RegWriteE=MemtoRegE=0, RsE=RtE=0. Write to r0 with ResultW=5 → r0 still reads 0.
- Jump wrap: j with InstrD[7:0]=0xFF → PCBranchD=0xFF. beq with PCPlus1D=0xFE, imm=+3 → PCBranchD=0x01. bne with DECODE_BNE_EN and r1≠r2 → PCSrcD=1.
